// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the ps2_keyboard FIFO, folds
// E0/F0 prefixes into one event per key, and tracks held key, shift and press count.
module ps2_key_decoder #(
    parameter int CNT_W         = 8,
    parameter bit REPEAT_FILTER = 1'b1,
    parameter bit SHIFT_EN      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    input  logic             cnt_clr,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic [7:0]       key_ascii,
    output logic             held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] byte_q;
    logic       ext_pend;
    logic       brk_pend;
    logic       shift_l;
    logic       shift_r;

    logic       decoding;
    logic       is_ext_prefix;
    logic       is_brk_prefix;
    logic       is_dropped;
    logic       ev_fire;
    logic [8:0] ev_id;
    logic       ev_repeat;
    logic       ev_new_make;
    logic       upper;
    logic [7:0] ev_ascii;

    // Lower-case ASCII for set-2 letter codes, 0x00 when the code is not a letter.
    function automatic logic [7:0] letter_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61;
            8'h32: a = 8'h62;
            8'h21: a = 8'h63;
            8'h23: a = 8'h64;
            8'h24: a = 8'h65;
            8'h2B: a = 8'h66;
            8'h34: a = 8'h67;
            8'h33: a = 8'h68;
            8'h43: a = 8'h69;
            8'h3B: a = 8'h6A;
            8'h42: a = 8'h6B;
            8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;
            8'h31: a = 8'h6E;
            8'h44: a = 8'h6F;
            8'h4D: a = 8'h70;
            8'h15: a = 8'h71;
            8'h2D: a = 8'h72;
            8'h1B: a = 8'h73;
            8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;
            8'h2A: a = 8'h76;
            8'h1D: a = 8'h77;
            8'h22: a = 8'h78;
            8'h35: a = 8'h79;
            8'h1A: a = 8'h7A;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Digits, space, enter and backspace; shift never alters these.
    function automatic logic [7:0] other_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each byte walks IDLE -> POP -> DECODE; IDLE always lasts at least one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ps2_ready) next_state = POP;
            POP:     next_state = DECODE;
            DECODE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The pop strobe is registered off next_state so it is low exactly during POP.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_nextdata_n <= 1'b1;
            byte_q         <= 8'h00;
        end else begin
            ps2_nextdata_n <= (next_state != POP);
            if (state == POP) begin
                byte_q <= ps2_data;
            end
        end
    end

    always_comb begin
        decoding      = (state == DECODE);
        is_ext_prefix = (byte_q == 8'hE0);
        is_brk_prefix = (byte_q == 8'hF0);
        is_dropped    = (byte_q == 8'h00) || (byte_q == 8'hFF) || (byte_q == 8'hFA) ||
                        (byte_q == 8'hAA) || (byte_q == 8'hEE);
        ev_fire       = decoding && !is_ext_prefix && !is_brk_prefix && !is_dropped;
        ev_id         = {ext_pend, byte_q};
        ev_repeat     = REPEAT_FILTER && !brk_pend && held && (held_code == ev_id);
        ev_new_make   = ev_fire && !brk_pend && !ev_repeat;
        upper         = SHIFT_EN && (shift_l || shift_r);
        ev_ascii      = 8'h00;
        if (!ext_pend) begin
            if (letter_ascii(byte_q) != 8'h00) begin
                ev_ascii = upper ? (letter_ascii(byte_q) - 8'h20) : letter_ascii(byte_q);
            end else begin
                ev_ascii = other_ascii(byte_q);
            end
        end
    end

    // Prefix flags accumulate across bytes; any non-prefix byte consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (decoding) begin
            if (is_ext_prefix) begin
                ext_pend <= 1'b1;
            end else if (is_brk_prefix) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // Shift bits follow make/break of the non-extended L/R shift codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (SHIFT_EN && ev_fire && !ext_pend) begin
            if (byte_q == 8'h12) shift_l <= !brk_pend;
            if (byte_q == 8'h59) shift_r <= !brk_pend;
        end
    end

    // Event fields are latched together and persist until the next event.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid  <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_repeat <= 1'b0;
            key_ascii  <= 8'h00;
        end else begin
            key_valid <= ev_fire;
            if (ev_fire) begin
                key_code   <= byte_q;
                key_ext    <= ext_pend;
                key_break  <= brk_pend;
                key_repeat <= ev_repeat;
                key_ascii  <= ev_ascii;
            end
        end
    end

    // A break only releases the key that is actually held; held_code is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            held      <= 1'b0;
            held_code <= 9'h000;
        end else if (ev_fire) begin
            if (ev_new_make) begin
                held      <= 1'b1;
                held_code <= ev_id;
            end else if (brk_pend && (ev_id == held_code)) begin
                held <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt <= '0;
        end else if (cnt_clr) begin
            press_cnt <= '0;
        end else if (ev_new_make) begin
            press_cnt <= press_cnt + CNT_W'(1);
        end
    end

    // A fresh overflow takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (ps2_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (cnt_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a small FIFO model feeds three instances
// (default, no repeat filter, 2-bit counter) and an event log is checked per sequence.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       cnt_clr;

    logic       nd_a, kv_a, kx_a, kb_a, kr_a, h_a, ovf_a;
    logic [7:0] kc_a, ka_a;
    logic [8:0] hc_a;
    logic [7:0] cnt_a;

    logic       nd_b, kv_b, kx_b, kb_b, kr_b, h_b, ovf_b;
    logic [7:0] kc_b, ka_b;
    logic [8:0] hc_b;
    logic [7:0] cnt_b;

    logic       nd_c, kv_c, kx_c, kb_c, kr_c, h_c, ovf_c;
    logic [7:0] kc_c, ka_c;
    logic [8:0] hc_c;
    logic [1:0] cnt_c;

    logic [7:0] fifo_mem [0:63];
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr = 6'd0;
    int         cyc = 0;

    int         ev_n = 0;
    int         ev_cyc   [0:63];
    logic [7:0] ev_code  [0:63];
    logic       ev_ext   [0:63];
    logic       ev_brk   [0:63];
    logic       ev_rep   [0:63];
    logic [7:0] ev_asc   [0:63];
    logic       ev_held  [0:63];
    logic [8:0] ev_hcode [0:63];
    logic [7:0] ev_cnt_a [0:63];
    logic [7:0] ev_cnt_b [0:63];
    logic [1:0] ev_cnt_c [0:63];

    int checks = 0;
    int passes = 0;
    int base;
    int c0;

    always #5 clk = ~clk;

    ps2_key_decoder dut_a (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd_a), .cnt_clr(cnt_clr),
        .key_valid(kv_a), .key_code(kc_a), .key_ext(kx_a), .key_break(kb_a),
        .key_repeat(kr_a), .key_ascii(ka_a), .held(h_a), .held_code(hc_a),
        .press_cnt(cnt_a), .ovf_sticky(ovf_a)
    );

    ps2_key_decoder #(.REPEAT_FILTER(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd_b), .cnt_clr(cnt_clr),
        .key_valid(kv_b), .key_code(kc_b), .key_ext(kx_b), .key_break(kb_b),
        .key_repeat(kr_b), .key_ascii(ka_b), .held(h_b), .held_code(hc_b),
        .press_cnt(cnt_b), .ovf_sticky(ovf_b)
    );

    ps2_key_decoder #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd_c), .cnt_clr(cnt_clr),
        .key_valid(kv_c), .key_code(kc_c), .key_ext(kx_c), .key_break(kb_c),
        .key_repeat(kr_c), .key_ascii(ka_c), .held(h_c), .held_code(hc_c),
        .press_cnt(cnt_c), .ovf_sticky(ovf_c)
    );

    assign ps2_ready = (wr_ptr != rd_ptr);
    assign ps2_data  = fifo_mem[rd_ptr];

    // FIFO pops on the edge that ends the cycle where nextdata_n is low.
    always @(posedge clk) begin
        if (!nd_a && ps2_ready) rd_ptr <= rd_ptr + 6'd1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (kv_a && ev_n < 64) begin
            ev_cyc[ev_n]   = cyc;
            ev_code[ev_n]  = kc_a;
            ev_ext[ev_n]   = kx_a;
            ev_brk[ev_n]   = kb_a;
            ev_rep[ev_n]   = kr_a;
            ev_asc[ev_n]   = ka_a;
            ev_held[ev_n]  = h_a;
            ev_hcode[ev_n] = hc_a;
            ev_cnt_a[ev_n] = cnt_a;
            ev_cnt_b[ev_n] = cnt_b;
            ev_cnt_c[ev_n] = cnt_c;
            ev_n = ev_n + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            passes = passes + 1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkEvent(input string tag, input int idx, input logic [7:0] code,
                              input logic ext, input logic brk, input logic rep,
                              input logic [7:0] asc);
        if (idx >= 64) begin
            checkOutput({tag, "_idx"}, 32'(idx), 32'd0);
        end else begin
            checkOutput({tag, "_code"}, 32'(ev_code[idx]), 32'(code));
            checkOutput({tag, "_ext"}, 32'(ev_ext[idx]), 32'(ext));
            checkOutput({tag, "_brk"}, 32'(ev_brk[idx]), 32'(brk));
            checkOutput({tag, "_rep"}, 32'(ev_rep[idx]), 32'(rep));
            checkOutput({tag, "_ascii"}, 32'(ev_asc[idx]), 32'(asc));
        end
    endtask

    task automatic pulseClear();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        cnt_clr      = 1'b0;
        ps2_overflow = 1'b0;
        wr_ptr       = 6'd0;
        waitCycles(3);
        checkOutput("rst_nextdata_n", 32'(nd_a), 32'd1);
        checkOutput("rst_valid", 32'(kv_a), 32'd0);
        checkOutput("rst_code", 32'(kc_a), 32'd0);
        checkOutput("rst_ascii", 32'(ka_a), 32'd0);
        checkOutput("rst_held", 32'(h_a), 32'd0);
        checkOutput("rst_held_code", 32'(hc_a), 32'd0);
        checkOutput("rst_cnt", 32'(cnt_a), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b0;
        waitCycles(2);

        // Make then break of 'q', with latency checks.
        base = ev_n;
        c0   = cyc;
        applyStimulus(8'h15); applyStimulus(8'hF0); applyStimulus(8'h15);
        waitCycles(1);
        checkOutput("t1_pop_low", 32'(nd_a), 32'd0);
        waitCycles(1);
        checkOutput("t1_pop_high", 32'(nd_a), 32'd1);
        checkOutput("t1_no_early_valid", 32'(kv_a), 32'd0);
        waitCycles(11);
        checkOutput("t1_events", 32'(ev_n - base), 32'd2);
        checkOutput("t1_make_cycle", 32'(ev_cyc[base]), 32'(c0 + 3));
        checkEvent("t1_make", base, 8'h15, 1'b0, 1'b0, 1'b0, 8'h71);
        checkOutput("t1_make_cnt", 32'(ev_cnt_a[base]), 32'd1);
        checkOutput("t1_make_held", 32'(ev_held[base]), 32'd1);
        checkOutput("t1_brk_cycle", 32'(ev_cyc[base+1]), 32'(c0 + 9));
        checkOutput("t1_brk_flag", 32'(ev_brk[base+1]), 32'd1);
        checkOutput("t1_brk_held", 32'(ev_held[base+1]), 32'd0);
        checkOutput("t1_fields_hold", 32'({kb_a, kc_a}), 32'h115);

        // Shifted 'd', then shift released.
        pulseClear();
        base = ev_n;
        applyStimulus(8'h12); applyStimulus(8'h23); applyStimulus(8'hF0);
        applyStimulus(8'h23); applyStimulus(8'hF0); applyStimulus(8'h12);
        waitCycles(20);
        checkOutput("t2_events", 32'(ev_n - base), 32'd4);
        checkEvent("t2_d", base + 1, 8'h23, 1'b0, 1'b0, 1'b0, 8'h44);
        checkOutput("t2_cnt", 32'(cnt_a), 32'd2);
        checkOutput("t2_held_after", 32'(h_a), 32'd0);

        // Repeated 'a' with and without the repeat filter; lower case proves shift is clear.
        pulseClear();
        base = ev_n;
        applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
        waitCycles(11);
        checkOutput("t3_events", 32'(ev_n - base), 32'd3);
        checkEvent("t3_first", base, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        checkOutput("t3_rep1", 32'(ev_rep[base+1]), 32'd1);
        checkOutput("t3_rep2", 32'(ev_rep[base+2]), 32'd1);
        checkOutput("t3_cnt_filter", 32'(cnt_a), 32'd1);
        checkOutput("t3_cnt_nofilter", 32'(cnt_b), 32'd3);
        checkOutput("t3_nofilter_rep", 32'(kr_b), 32'd0);

        // Extended key make and break.
        base = ev_n;
        applyStimulus(8'hE0); applyStimulus(8'h75); applyStimulus(8'hE0);
        applyStimulus(8'hF0); applyStimulus(8'h75);
        waitCycles(17);
        checkOutput("t4_events", 32'(ev_n - base), 32'd2);
        checkEvent("t4_make", base, 8'h75, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("t4_make_hcode", 32'(ev_hcode[base]), 32'h175);
        checkOutput("t4_make_cnt", 32'(ev_cnt_a[base]), 32'd2);
        checkEvent("t4_brk", base + 1, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("t4_brk_held", 32'(ev_held[base+1]), 32'd0);
        checkOutput("t4_brk_hcode", 32'(hc_a), 32'h175);

        // Narrow counter wraps; overflow sticky and clear priority.
        pulseClear();
        base = ev_n;
        applyStimulus(8'h16); applyStimulus(8'h1E); applyStimulus(8'h26);
        applyStimulus(8'h25); applyStimulus(8'h2E);
        waitCycles(17);
        checkOutput("t5_events", 32'(ev_n - base), 32'd5);
        checkOutput("t5_ascii_1", 32'(ev_asc[base]), 32'h31);
        checkOutput("t5_cnt_0", 32'(ev_cnt_c[base]), 32'd1);
        checkOutput("t5_cnt_1", 32'(ev_cnt_c[base+1]), 32'd2);
        checkOutput("t5_cnt_2", 32'(ev_cnt_c[base+2]), 32'd3);
        checkOutput("t5_cnt_3", 32'(ev_cnt_c[base+3]), 32'd0);
        checkOutput("t5_cnt_4", 32'(ev_cnt_c[base+4]), 32'd1);
        checkOutput("t5_cnt_wide", 32'(cnt_a), 32'd5);
        checkOutput("t5_ovf_idle", 32'(ovf_a), 32'd0);
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        checkOutput("t5_ovf_set", 32'(ovf_a), 32'd1);
        pulseClear();
        checkOutput("t5_clr_cnt", 32'(cnt_c), 32'd0);
        checkOutput("t5_clr_cnt_wide", 32'(cnt_a), 32'd0);
        checkOutput("t5_clr_ovf", 32'(ovf_a), 32'd0);
        ps2_overflow = 1'b1;
        cnt_clr      = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        cnt_clr      = 1'b0;
        checkOutput("t5_set_wins", 32'(ovf_a), 32'd1);

        // Dropped byte cancels a pending break.
        base = ev_n;
        applyStimulus(8'hF0); applyStimulus(8'hAA); applyStimulus(8'h1D);
        waitCycles(11);
        checkOutput("t6_events", 32'(ev_n - base), 32'd1);
        checkEvent("t6_w", base, 8'h1D, 1'b0, 1'b0, 1'b0, 8'h77);

        // Reset during POP loses the byte and discards a pending break prefix.
        base = ev_n;
        applyStimulus(8'hF0);
        waitCycles(4);
        applyStimulus(8'h16);
        waitCycles(1);
        checkOutput("t7_in_pop", 32'(nd_a), 32'd0);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("t7_rst_nd", 32'(nd_a), 32'd1);
        waitCycles(4);
        checkOutput("t7_no_event", 32'(ev_n - base), 32'd0);
        checkOutput("t7_code", 32'(kc_a), 32'd0);
        checkOutput("t7_held", 32'(h_a), 32'd0);
        checkOutput("t7_cnt", 32'(cnt_a), 32'd0);
        checkOutput("t7_ovf", 32'(ovf_a), 32'd0);
        applyStimulus(8'h1D);
        waitCycles(5);
        checkOutput("t7_after_events", 32'(ev_n - base), 32'd1);
        checkEvent("t7_after", base, 8'h1D, 1'b0, 1'b0, 1'b0, 8'h77);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Scan-code decoder between the `ps2_keyboard` receive FIFO and the display/segment logic. It pops bytes from the FIFO with the `nextdata_n` handshake and decodes PS/2 set-2 make, break and E0-extended sequences. Each completed key produces a one-cycle event carrying the code, the ASCII value, the break/extended/repeat flags, the held-key state and a press counter. It replaces the ad-hoc per-design make/break state machine and is parametrised in counter width, repeat filtering and shift handling.

## Interface
- `CNT_W`, default 8: width of `press_cnt`.
- `REPEAT_FILTER`, default 1: when 1, a repeated make of the currently held key is flagged as repeat and is not counted.
- `SHIFT_EN`, default 1: when 1, track the L/R shift keys and upper-case letters in `key_ascii`.

Ports:
- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous, active-high reset.
- `ps2_data`  in  8: FIFO head byte from `ps2_keyboard`.
- `ps2_ready`  in  1: FIFO non-empty.
- `ps2_overflow`  in  1: FIFO overflow flag.
- `ps2_nextdata_n`  out  1: active-low pop; registered.
- `cnt_clr`  in  1: synchronous clear of `press_cnt` and `ovf_sticky`.
- `key_valid`  out  1: one-cycle event strobe.
- `key_code`  out  8: scan code, without prefixes.
- `key_ext`  out  1: event was E0-prefixed.
- `key_break`  out  1: event is a release.
- `key_repeat`  out  1: make of an already-held key.
- `key_ascii`  out  8: ASCII of the event key, or 0x00 if unmapped.
- `held`  out  1: a key is currently held.
- `held_code`  out  9: {ext, code} of the held key.
- `press_cnt`  out  CNT_W: count of new (non-repeat) makes.
- `ovf_sticky`  out  1: latched copy of `ps2_overflow`.

## Operation
- FSM states:
  - IDLE: if `ps2_ready`=1, go to POP.
  - POP: drive `ps2_nextdata_n`=0, capture `ps2_data` into `byte_q`, go to DECODE.
  - DECODE: `ps2_nextdata_n`=1; decode `byte_q`; go to IDLE.
  - Each byte takes exactly 3 cycles. IDLE blocks for one cycle after DECODE, so the FIFO `ready` has settled before the next pop.
- Byte decode in DECODE:
  - 0xE0: set `ext_pend`. No event.
  - 0xF0: set `brk_pend`. No event.
  - 0x00, 0xFF, 0xFA, 0xAA, 0xEE: dropped. Clear both pending flags. No event.
  - Any other byte: emit an event with `key_code`=byte, `key_ext`=`ext_pend`, `key_break`=`brk_pend`. Clear both pending flags.
- Make event:
  - If `REPEAT_FILTER`=1, `held`=1 and `held_code`=={ext, code}: set `key_repeat`=1 and leave the counter unchanged.
  - Otherwise: increment `press_cnt` (wraps modulo 2^CNT_W), set `held`=1 and `held_code`={ext, code}.
- Break event: if {ext, code}==`held_code`, clear `held` (`held_code` keeps its value). A break of a non-held key still emits its event and leaves `held` unchanged.
- Shift (only when `SHIFT_EN`=1): non-extended make of 0x12 or 0x59 sets the corresponding shift bit; its break clears it. Shift key events are counted like any other key.
- ASCII mapping (non-extended codes only; extended → 0x00):
  - Set-2 letters a–z give 0x61–0x7A, or 0x41–0x5A when either shift bit is set.
  - Digits 0–9 give 0x30–0x39, unaffected by shift.
  - 0x29 gives 0x20, 0x5A gives 0x0D, 0x66 gives 0x08.
  - All other codes give 0x00.
  - `key_ascii` uses the shift state as it was before the current event.
- `cnt_clr` clears `press_cnt` and `ovf_sticky`. `ps2_overflow`=1 sets `ovf_sticky`. If both occur in the same cycle, set wins.

## Timing
- Reset values:
  - `ps2_nextdata_n`=1; FSM=IDLE.
  - `key_valid`=0, `key_code`=0, `key_ext`=0, `key_break`=0, `key_repeat`=0, `key_ascii`=0.
  - `held`=0, `held_code`=0, `press_cnt`=0, `ovf_sticky`=0.
  - Pending flags cleared; shift bits cleared.
- Latency: `ps2_ready` sampled high in cycle n (IDLE) → `ps2_nextdata_n` low in cycle n+1 → `key_valid` high in cycle n+3, for exactly 1 cycle.
- `key_*` fields are registered with `key_valid` and hold their value until the next event. `held`, `held_code`, `press_cnt` and shift update in the same cycle as `key_valid`.
- A full 3-byte break sequence (E0 F0 xx) takes 9 cycles from the first `ps2_ready`. Bytes already in the FIFO are consumed back-to-back at one byte per 3 cycles.
- Reset asserted in POP: the popped byte is lost, `ps2_nextdata_n`=1 in the next cycle, and any partial prefix is discarded.
- `ps2_ready` dropping while in POP/DECODE has no effect. The captured byte is decoded.

## Test plan
- Reset, then push 0x15, 0xF0, 0x15 → 3 pops. Events: make code=0x15 ascii=0x71 (`press_cnt`=1, `held`=1), then break code=0x15 (`held`=0). Exactly 2 `key_valid` pulses, each 1 cycle, at n+3 timing.
- Push 0x12, 0x23, 0xF0, 0x23, 0xF0, 0x12 → 'd' event has ascii=0x44. `press_cnt`=2. Shift is clear after the final break.
- `REPEAT_FILTER`=1, push 0x1C ×3 → first event repeat=0, next two repeat=1. `press_cnt`=1. Same test with `REPEAT_FILTER`=0 → `press_cnt`=3.
- Push 0xE0, 0x75, 0xE0, 0xF0, 0x75 → events code=0x75, ext=1, ascii=0x00. `held_code`=0x175, then `held`=0.
- `CNT_W`=2, push 5 distinct makes → `press_cnt` sequence 1,2,3,0,1. Pulse `ps2_overflow` → `ovf_sticky`=1. `cnt_clr` → both return to 0.
- Push 0xF0, 0xAA, 0x1D → 0xAA is dropped and clears `brk_pend`. Event is a make of 0x1D (ascii 0x77). Assert `rst` in POP of a 0x16 byte → no event; outputs return to their reset values.
